// File: rtl/quadrant_reducer_q16.sv
// quadrant_reducer_q16: reduces a signed Q16.16 angle modulo 2*pi and folds it into [0, pi/2] for CORDIC
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     angle_in handshake (signed Q16.16 radians)
//   out_valid/out_ready   result handshake
//   angle_out             folded angle, 0..C_PI2
//   kuadran, isNegative   quadrant of |angle| mod 2*pi and input sign, for post-CORDIC sign fix-up
module quadrant_reducer_q16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] angle_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] angle_out,
   output logic [1:0]  kuadran,
   output logic        isNegative
);
   localparam logic [31:0] C_2PI  = 32'd411775;
   localparam logic [31:0] C_PI   = 32'd205887;
   localparam logic [31:0] C_PI2  = 32'd102944;
   localparam logic [31:0] C_3PI2 = 32'd308831;
   typedef enum logic [1:0] {IDLE, REDUCE, FOLD, DONE} state_t;
   state_t      state;
   logic [31:0] rem, mag, sub, fa;
   logic [3:0]  k;
   logic [1:0]  fk;
   logic        neg;
   // two's-complement negate keeps -2^31 as 2^31 when read unsigned
   assign mag = angle_in[31] ? -angle_in : angle_in;
   // C_2PI << 12 still fits in 32 bits, so 13 restoring steps cover any |angle_in|
   assign sub = C_2PI << k;
   assign in_ready = state == IDLE;
   always_comb begin
      fk = rem < C_PI2 ? 2'd0 : rem < C_PI ? 2'd1 : rem < C_3PI2 ? 2'd2 : 2'd3;
      fa = rem < C_PI2 ? rem : rem < C_PI ? C_PI - rem : rem < C_3PI2 ? rem - C_PI : C_2PI - rem;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rem        <= '0;
         k          <= '0;
         neg        <= 1'b0;
         out_valid  <= 1'b0;
         angle_out  <= '0;
         kuadran    <= '0;
         isNegative <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               neg   <= angle_in[31];
               rem   <= mag;
               k     <= 4'd12;
               state <= REDUCE;
            end
            REDUCE: begin
               if (rem >= sub) rem <= rem - sub;
               if (k == 4'd0) state <= FOLD;
               else k <= k - 4'd1;
            end
            FOLD: begin
               angle_out  <= fa;
               kuadran    <= fk;
               isNegative <= neg;
               out_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/quadrant_reducer_q16.md
# quadrant_reducer_q16

Multi-cycle angle pre-processor for the Q16.16 CORDIC sin/cos path. It takes an arbitrary signed Q16.16 angle in radians and reduces it modulo 2π. It then folds the result into the first quadrant [0, π/2] and emits the `kuadran` and `isNegative` tags that the post-CORDIC sign-correction stage uses to restore the correct signs. It sits between the angle source and the CORDIC rotation core, with valid/ready handshakes on both sides.

## Interface
- No parameters. Constants are fixed, in Q16.16: C_2PI = 411775, C_PI = 205887, C_PI2 = 102944, C_3PI2 = 308831.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input angle valid.
- `in_ready`  out  1  block can accept an angle.
- `angle_in`  in  32  signed Q16.16 angle, radians.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `angle_out`  out  32  signed Q16.16 reduced angle, always in 0..C_PI2.
- `kuadran`  out  2  quadrant of |angle| mod 2π (0..3).
- `isNegative`  out  1  1 when `angle_in` < 0.

## Operation
- FSM states: IDLE, REDUCE, FOLD, DONE.
- IDLE
  - `in_ready` = 1.
  - On `in_valid` && `in_ready`, latch `isNegative` = `angle_in`[31].
  - Latch rem = |angle_in| as 32-bit unsigned. |−2^31| = 2^31 exactly, with no saturation.
  - Set k = 12 and go to REDUCE.
- REDUCE: one restoring step per cycle, for k = 12 down to 0.
  - If rem ≥ (C_2PI << k), subtract (C_2PI << k) from rem.
  - All operands are 32-bit unsigned; C_2PI << 12 = 1686630400 fits in 32 bits.
  - After the k = 0 step, go to FOLD. At that point rem < C_2PI is guaranteed.
- FOLD: classify with half-open ranges and register the outputs.
  - rem < C_PI2: `kuadran` = 0, `angle_out` = rem.
  - rem < C_PI: `kuadran` = 1, `angle_out` = C_PI − rem.
  - rem < C_3PI2: `kuadran` = 2, `angle_out` = rem − C_PI.
  - otherwise: `kuadran` = 3, `angle_out` = C_2PI − rem.
  - Go to DONE.
- DONE
  - `out_valid` = 1. `angle_out`, `kuadran` and `isNegative` are held stable.
  - On `out_ready`, go to IDLE.
- `in_ready` = 0 in REDUCE, FOLD and DONE. `in_valid` is ignored there; no buffering and no error flag.
- Zero input gives `kuadran` 0, `isNegative` 0, `angle_out` 0.

## Timing
- Reset (async, immediate, also mid-operation):
  - state = IDLE, so `in_ready` = 1 as soon as `rst` deasserts.
  - `out_valid` = 0, `angle_out` = 0, `kuadran` = 0, `isNegative` = 0.
  - Any in-flight angle is discarded.
- Latency: with the accept edge as E0, REDUCE runs on E1..E13 and FOLD on E14. `out_valid` is high from E14 onward, a fixed 14 cycles that does not depend on data.
- The output handshake completes on the first edge with `out_valid` && `out_ready`. The next edge is the earliest accept, so minimum initiation interval is 16 cycles with `out_ready` held high.
- Outputs are registered. They change only at the FOLD → DONE edge and on reset.

## Test plan
- `angle_in` = 65536 (1.0 rad), `out_ready` = 1 → `out_valid` 14 cycles after accept, with `kuadran` 0, `isNegative` 0, `angle_out` 65536.
- `angle_in` = 131072 (2.0) → `kuadran` 1, `angle_out` 74815, `isNegative` 0.
- `angle_in` = −262144 (−4.0) → `kuadran` 2, `angle_out` 56257, `isNegative` 1.
- `angle_in` = 655360 (10.0) → rem 243585, `kuadran` 2, `angle_out` 37698. Also `angle_in` = 0x80000000 → rem 77023, `kuadran` 0, `angle_out` 77023, `isNegative` 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles in DONE and pulse `in_valid` with a new angle → outputs stable, `in_ready` 0, new angle not accepted. Raising `out_ready` returns to IDLE on the next edge.
- Assert `rst` during REDUCE (cycle 6) → `out_valid` 0 and outputs 0 immediately, `in_ready` 1 after release. A fresh angle 102944 then yields `kuadran` 1, `angle_out` 102943.
